// File: rtl/picoblaze_io_hub.sv
// picoblaze_io_hub
// I/O hub for a PicoBlaze-style processor bus. It provides:
//   - NUM_OUT write-only output registers at OUT_BASE+k, each with a
//     one-cycle write pulse,
//   - NUM_IN read-only input ports at IN_BASE+k,
//   - an interrupt block at IRQ_BASE+0..3 (pending, mask, W1C clear, levels).
// Optional feature: define PICOBLAZE_IO_HUB_IRQ_SYNC_EN to pass every irq_src
// bit through a two-flop synchroniser before edge detection. When the macro is
// undefined, irq_src must already be synchronous to clk.
//
// Bus semantics: write_strobe qualifies port_id/out_port for exactly the
// cycle it is high, and the write takes effect on that rising edge. Reads
// need no qualifier: in_port is re-registered from port_id on every edge,
// so read data always appears one cycle after the address. read_strobe is
// accepted but causes no side effects. interrupt_ack is a one-cycle pulse
// that forces interrupt low in the following cycle.
module picoblaze_io_hub #(
  parameter int         NUM_OUT  = 2,
  parameter int         NUM_IN   = 1,
  parameter int         NUM_IRQ  = 1,
  parameter logic [7:0] OUT_BASE = 8'h80,
  parameter logic [7:0] IN_BASE  = 8'h00,
  parameter logic [7:0] IRQ_BASE = 8'hF0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic [7:0]             out_port,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  output logic [7:0]             in_port,
  output logic                   interrupt,
  input  logic                   interrupt_ack,
  input  logic [8*NUM_IN-1:0]    in_data,
  output logic [8*NUM_OUT-1:0]   out_data,
  output logic [NUM_OUT-1:0]     out_wr_pulse,
  input  logic [NUM_IRQ-1:0]     irq_src
);

  // Interrupt block register map.
  localparam logic [7:0] IRQ_PEND_ADDR = IRQ_BASE;
  localparam logic [7:0] IRQ_MASK_ADDR = IRQ_BASE + 8'd1;
  localparam logic [7:0] IRQ_CLR_ADDR  = IRQ_BASE + 8'd2;
  localparam logic [7:0] IRQ_LVL_ADDR  = IRQ_BASE + 8'd3;

  // Registered state.
  logic [NUM_OUT-1:0][7:0] r_out_data;
  logic [NUM_OUT-1:0]      r_wr_pulse;
  logic [NUM_IRQ-1:0]      r_mask;
  logic [NUM_IRQ-1:0]      r_pending;
  logic [NUM_IRQ-1:0]      r_irq_hist;
  logic                    r_interrupt;
  logic [7:0]              r_in_port;

  // Combinational decode and datapath.
  logic [NUM_OUT-1:0]      w_out_sel;
  logic                    w_mask_wr;
  logic                    w_clr_wr;
  logic [NUM_IRQ-1:0]      w_irq_lvl;
  logic [NUM_IRQ-1:0]      w_irq_rise;
  logic [NUM_IRQ-1:0]      w_clr_bits;
  logic [7:0]              w_pend_rd;
  logic [7:0]              w_mask_rd;
  logic [7:0]              w_lvl_rd;
  logic [7:0]              w_rd_data;
  logic                    w_unused_rd_strobe;

  // read_strobe has no function in this hub; it is kept on the port list
  // so the block drops straight onto the processor bus.
  assign w_unused_rd_strobe = read_strobe;

`ifdef PICOBLAZE_IO_HUB_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync_meta;
  logic [NUM_IRQ-1:0] r_sync_out;

  // Two-flop synchroniser; deliberately not reset so it keeps tracking
  // the sources while reset is held.
  always_ff @(posedge clk) begin
    r_sync_meta <= irq_src;
    r_sync_out  <= r_sync_meta;
  end

  assign w_irq_lvl = r_sync_out;
`else
  assign w_irq_lvl = irq_src;
`endif

  // Edge history also runs through reset, so a source that is already high
  // when reset is released does not register as a new edge.
  always_ff @(posedge clk) begin
    r_irq_hist <= w_irq_lvl;
  end

  assign w_irq_rise = w_irq_lvl & ~r_irq_hist;

  // Exact 8-bit address match for output register writes.
  always_comb begin
    w_out_sel = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_out_sel[k] = write_strobe && (port_id == (OUT_BASE + 8'(k)));
    end
  end

  assign w_mask_wr  = write_strobe && (port_id == IRQ_MASK_ADDR);
  assign w_clr_wr   = write_strobe && (port_id == IRQ_CLR_ADDR);
  assign w_clr_bits = w_clr_wr ? out_port[NUM_IRQ-1:0] : '0;

  // Output registers load on a matching write; the pulse marks the
  // cycle in which the new value first appears on out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_out_sel;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_out_sel[k]) begin
          r_out_data[k] <= out_port;
        end
      end
    end
  end

  // Mask register; only the implemented source bits exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_mask_wr) begin
      r_mask <= out_port[NUM_IRQ-1:0];
    end
  end

  // Pending bits: W1C clears first, then a new edge sets, so a set that
  // collides with a clear on the same bit is never lost. Mask has no say.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_bits) | w_irq_rise;
    end
  end

  // Registered interrupt request; an acknowledge forces one low cycle,
  // after which the request reappears if anything enabled is still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_interrupt <= 1'b0;
    end else if (interrupt_ack) begin
      r_interrupt <= 1'b0;
    end else begin
      r_interrupt <= |(r_pending & r_mask);
    end
  end

  // Zero-extend the interrupt registers to a full byte for readback.
  always_comb begin
    w_pend_rd = '0;
    w_mask_rd = '0;
    w_lvl_rd  = '0;
    w_pend_rd[NUM_IRQ-1:0] = r_pending;
    w_mask_rd[NUM_IRQ-1:0] = r_mask;
    w_lvl_rd[NUM_IRQ-1:0]  = w_irq_lvl;
  end

  // Read decode: exact match on port_id, unmapped addresses read 8'h00.
  always_comb begin
    w_rd_data = 8'h00;
    for (int k = 0; k < NUM_IN; k++) begin
      if (port_id == (IN_BASE + 8'(k))) begin
        w_rd_data = in_data[8*k +: 8];
      end
    end
    if (port_id == IRQ_PEND_ADDR) begin
      w_rd_data = w_pend_rd;
    end else if (port_id == IRQ_MASK_ADDR) begin
      w_rd_data = w_mask_rd;
    end else if (port_id == IRQ_LVL_ADDR) begin
      w_rd_data = w_lvl_rd;
    end
  end

  // Read data register, refreshed on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_port <= 8'h00;
    end else begin
      r_in_port <= w_rd_data;
    end
  end

  assign in_port      = r_in_port;
  assign interrupt    = r_interrupt;
  assign out_data     = r_out_data;
  assign out_wr_pulse = r_wr_pulse;

endmodule
